// File: rtl/vnu_pe.sv
// LDPC variable-node PE: iterates edge messages with DV check nodes.
// Optional early termination on zero syndrome: define VNU_EARLY_TERM_EN.

module vnu_phi_lut (
    input  logic [5:0] mag,
    output logic [3:0] phi
);
    // phi(x) = -ln(tanh(x/2)); input LSB 1/8, output LSB 1/4, rounded
    always_comb begin
        phi = 4'd0;
        case (mag)
            6'd0:                  phi = 4'd15;
            6'd1:                  phi = 4'd11;
            6'd2:                  phi = 4'd8;
            6'd3:                  phi = 4'd7;
            6'd4:                  phi = 4'd6;
            6'd5:                  phi = 4'd5;
            6'd6, 6'd7:            phi = 4'd4;
            6'd8, 6'd9:            phi = 4'd3;
            6'd10, 6'd11,
            6'd12, 6'd13:          phi = 4'd2;
            default:               phi = (mag <= 6'd22) ? 4'd1 : 4'd0;
        endcase
    end
endmodule

module vnu_pe #(
    parameter int DV       = 3,
    parameter int MAX_ITER = 8,
    parameter int CNU_LAT  = 1,
    parameter int SUM_W    = 8,
    localparam int IW      = $clog2(MAX_ITER + 1),
    localparam int WW      = (CNU_LAT > 1) ? $clog2(CNU_LAT) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      llr_in,
    output logic [6*DV-1:0] x_out,
    output logic            x_valid,
    input  logic [5*DV-1:0] y_in,
    input  logic            syndrome_zero,
    output logic            busy,
    output logic            done,
    output logic            hard_bit,
    output logic [IW-1:0]   iter_cnt
);

`ifdef VNU_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPUTE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic signed [SUM_W-1:0] llr_q;
    logic signed [SUM_W-1:0] r_q [DV];
    logic                    last_flag;
    logic                    synd_q;
    logic [WW-1:0]           wait_cnt;

    logic signed [SUM_W-1:0] total;
    logic signed [SUM_W-1:0] q [DV];
    logic [SUM_W-1:0]        qmag [DV];
    logic [5:0]              qsat [DV];
    logic [3:0]              qphi [DV];
    logic [6*DV-1:0]         edges;
    logic                    early_stop;
    logic                    wait_last;
    logic                    last_iter;

    function automatic logic signed [SUM_W-1:0] sm2tc(input logic [4:0] v);
        logic signed [SUM_W-1:0] m;
        m = '0;
        m[3:0] = v[3:0];
        return v[4] ? -m : m;
    endfunction

    assign early_stop = EARLY & synd_q;
    assign wait_last  = (wait_cnt == '0);
    assign last_iter  = ((iter_cnt + 1'b1) == IW'(MAX_ITER));

    always_comb begin
        total = llr_q;
        for (int j = 0; j < DV; j++)
            total = total + r_q[j];
    end

    for (genvar j = 0; j < DV; j++) begin : g_edge
        always_comb begin
            q[j]    = total - r_q[j];
            qmag[j] = q[j][SUM_W-1] ? SUM_W'(-q[j]) : SUM_W'(q[j]);
            qsat[j] = (qmag[j] > SUM_W'(63)) ? 6'd63 : qmag[j][5:0];
        end

        vnu_phi_lut u_phi (
            .mag (qsat[j]),
            .phi (qphi[j])
        );

        assign edges[6*j +: 6] = {total[SUM_W-1], q[j][SUM_W-1], qphi[j]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        x_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy    = 1'b1;
                state_n = last_flag ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                busy    = 1'b1;
                x_valid = 1'b1;
                if (wait_last) state_n = S_CHECK;
            end
            S_CHECK: begin
                busy    = 1'b1;
                state_n = early_stop ? S_DONE : S_COMPUTE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_n = S_COMPUTE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llr_q     <= '0;
            last_flag <= 1'b0;
            synd_q    <= 1'b0;
            wait_cnt  <= '0;
            iter_cnt  <= '0;
            x_out     <= '0;
            hard_bit  <= 1'b0;
            for (int j = 0; j < DV; j++)
                r_q[j] <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        llr_q     <= sm2tc(llr_in);
                        last_flag <= 1'b0;
                        synd_q    <= 1'b0;
                        iter_cnt  <= '0;
                        for (int j = 0; j < DV; j++)
                            r_q[j] <= '0;
                    end
                end
                S_COMPUTE: begin
                    x_out    <= edges;
                    hard_bit <= total[SUM_W-1];
                    wait_cnt <= WW'(CNU_LAT - 1);
                end
                S_WAIT: begin
                    if (wait_last) begin
                        synd_q <= syndrome_zero;
                        for (int j = 0; j < DV; j++)
                            r_q[j] <= sm2tc(y_in[5*j +: 5]);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    iter_cnt <= iter_cnt + 1'b1;
                    if (!early_stop && last_iter)
                        last_flag <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vnu_pe.sv
// Directed self-checking bench for vnu_pe (DV=3, MAX_ITER=8, CNU_LAT=1).
// Edge words are {hard, sign, phi}; expected phi values from the LUT table.

module tb_vnu_pe;

`ifdef VNU_EARLY_TERM_EN
    localparam int EXP_IT = 2;
`else
    localparam int EXP_IT = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  llr_in;
    logic [17:0] x_out;
    logic        x_valid;
    logic [14:0] y_in;
    logic        syndrome_zero;
    logic        busy;
    logic        done;
    logic        hard_bit;
    logic [3:0]  iter_cnt;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int k;

    always #5 clk = ~clk;

    vnu_pe dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .llr_in        (llr_in),
        .x_out         (x_out),
        .x_valid       (x_valid),
        .y_in          (y_in),
        .syndrome_zero (syndrome_zero),
        .busy          (busy),
        .done          (done),
        .hard_bit      (hard_bit),
        .iter_cnt      (iter_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        llr_in = '0;
        y_in = '0;
        syndrome_zero = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_xout", 32'(x_out), 32'h0);
        chk("rst_xvalid", 32'(x_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_iter", 32'(iter_cnt), 32'h0);
        rst = 1'b0;

        // L=+5, first iteration with r=0
        @(negedge clk);
        llr_in = 5'b00101;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cmp_busy", 32'(busy), 32'h1);
        chk("cmp_xvalid", 32'(x_valid), 32'h0);
        @(negedge clk);
        chk("it1_xvalid", 32'(x_valid), 32'h1);
        chk("it1_xout", 32'(x_out), 32'({3{6'h05}}));
        chk("it1_hard", 32'(hard_bit), 32'h0);
        y_in = {5'b00111, 5'b10010, 5'b00011};
        @(negedge clk);
        chk("chk_xvalid", 32'(x_valid), 32'h0);
        y_in = '0;
        @(negedge clk);
        chk("it2_iter", 32'(iter_cnt), 32'h1);
        @(negedge clk);
        chk("it2_xvalid", 32'(x_valid), 32'h1);
        chk("it2_xout", 32'(x_out), 32'({6'h04, 6'h01, 6'h02}));
        chk("it2_hard", 32'(hard_bit), 32'h0);

        // reset in the middle of WAIT
        rst = 1'b1;
        #1;
        chk("mrst_xout", 32'(x_out), 32'h0);
        chk("mrst_xvalid", 32'(x_valid), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_iter", 32'(iter_cnt), 32'h0);
        chk("mrst_hard", 32'(hard_bit), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // L=-4, replies {-15,-15,+1}; syndrome zero in iteration 2
        @(negedge clk);
        llr_in = 5'b10100;
        start  = 1'b1;
        y_in   = {5'b00001, 5'b11111, 5'b11111};
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (x_valid) begin
                k++;
                syndrome_zero = (k == 2);
                if (k == 1) begin
                    chk("neg_it1_xout", 32'(x_out), 32'({3{6'h36}}));
                    start  = 1'b1;
                    llr_in = 5'b00101;
                end
                if (k == 2) begin
                    chk("neg_it2_xout", 32'(x_out),
                        32'({6'h30, 6'h31, 6'h31}));
                    chk("neg_it2_hard", 32'(hard_bit), 32'h1);
                end
            end else begin
                syndrome_zero = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        syndrome_zero = 1'b0;
        chk("neg_done", 32'(done), 32'h1);
        chk("neg_busy", 32'(busy), 32'h0);
        chk("neg_iter", 32'(iter_cnt), 32'(EXP_IT));
        chk("neg_waits", 32'(k), 32'(EXP_IT));
        chk("neg_hard", 32'(hard_bit), 32'h1);
        chk("neg_xout", 32'(x_out), 32'({6'h30, 6'h31, 6'h31}));

        // restart from DONE: r must be cleared
        llr_in = 5'b00101;
        y_in   = '0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rs_done", 32'(done), 32'h0);
        chk("rs_busy", 32'(busy), 32'h1);
        chk("rs_iter", 32'(iter_cnt), 32'h0);
        @(negedge clk);
        chk("rs_xvalid", 32'(x_valid), 32'h1);
        chk("rs_xout", 32'(x_out), 32'({3{6'h05}}));
        k = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (x_valid) k++;
            @(negedge clk);
        end
        chk("rs_fin_done", 32'(done), 32'h1);
        chk("rs_fin_iter", 32'(iter_cnt), 32'h8);
        chk("rs_fin_waits", 32'(k), 32'h8);
        chk("rs_fin_hard", 32'(hard_bit), 32'h0);
        chk("rs_fin_xout", 32'(x_out), 32'({3{6'h05}}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
